freq_meas_ctrl: RTL
===================

// Module: freq_meas_ctrl
// PURPOSE
//  Reference-clock-side controller for the ring-oscillator edge counter.
//  Drives the counter's clear strobe (meas_clk) and count window (meas_en), then captures the frozen count.
//  Emits a result word on a valid/ready handshake. Sits between osc counter and readout/scan logic.
// PARAMETERS
//  N        8   width of counter value and result
//  GW       16  width of gate_len (window length in clk cycles)
//  CLR_CYC  4   clk cycles meas_clk held high to clear the counter (>=2)
//  HOLD_CYC 4   clk cycles after meas_en falls before the first sample (osc settle)
//  MAX_TRY  8   max sample attempts before flagging err
// PORTS
//  clk          in   1   reference clock; all logic on posedge
//  reset        in   1   synchronous, active-low reset
//  start        in   1   request one measurement; sampled in IDLE only
//  cont         in   1   1: auto-restart after each handshake
//  gate_len     in   GW  window length in clk cycles; 0 is treated as 1
//  count_in     in   N   counter value (asynchronous to clk)
//  meas_clk     out  1   clear strobe to counter
//  meas_en      out  1   count enable to counter
//  result       out  N   captured count
//  result_valid out  1   result available
//  result_ready in   1   consumer accepts result
//  busy         out  1   FSM not in IDLE
//  err          out  1   sticky: sample never stabilised; cleared on next start
// BEHAVIOUR
//  Reset (reset==0 at posedge): state IDLE; meas_clk=0, meas_en=0, result=0, result_valid=0, busy=0, err=0.
//  FSM: IDLE->CLEAR->GATE->HOLD->SAMPLE->DONE->IDLE; all outputs registered.
//  IDLE: start==1 -> CLEAR next cycle; latch gate_len; clear err.
//  CLEAR: meas_clk=1, meas_en=0 for exactly CLR_CYC cycles.
//  GATE: meas_clk=0, meas_en=1 for exactly max(gate_len,1) cycles.
//  HOLD: meas_en=0, meas_clk=0 for HOLD_CYC cycles.
//  SAMPLE: 2-flop sync of count_in, then compare consecutive synced samples each cycle.
//   Two equal samples -> result<=value, DONE.
//   After MAX_TRY mismatches -> result<=last sample, err<=1, DONE.
//  DONE: result_valid=1, result stable until result_valid&&result_ready.
//   Handshake cycle: result_valid<=0; cont==1 -> CLEAR, else IDLE.
//   Handshake may occur in the first DONE cycle.
//  start while busy is ignored. gate_len changes mid-measurement have no effect until the next start.
//  Window counter: GW bits, no wrap; gate_len=all-ones gives 2^GW-1 cycles.
//  Reset mid-operation: returns to IDLE next edge; meas_en drops; pending result is discarded.
//  Latency from start (IDLE) to result_valid, best case: 1+CLR_CYC+max(gate_len,1)+HOLD_CYC+2+2 cycles.
// CONFIGURATION
//  FREQ_MEAS_AVG_EN defined:
//   Parameter AVG_LOG2 (default 2). Runs 2^AVG_LOG2 CLEAR..SAMPLE passes, summed in an N+AVG_LOG2 accumulator.
//   result = sum>>AVG_LOG2 (truncate). err is set if any pass errs.
//   result_valid only after the final pass.
//  FREQ_MEAS_AVG_EN undefined: single pass; no accumulator logic.
// STRUCTURE
//  Package freq_meas_pkg: FSM state enum (IDLE,CLEAR,GATE,HOLD,SAMPLE,DONE); default constants for CLR_CYC/HOLD_CYC/MAX_TRY.
//  Sub-module freq_meas_sync: N-bit 2-flop synchroniser plus equal-consecutive-sample detector (stable, value out).
// TESTING
//  1 Reset: hold reset=0 3 cycles mid-GATE -> meas_en=0, busy=0, result_valid=0 next edge.
//  2 Single shot: gate_len=10; behavioural osc counter at 3x clk -> meas_clk high 4 cycles, meas_en high 10 cycles.
//     result ~30 (+/-3), err=0, result_valid at cycle 23 after start.
//  3 Backpressure: result_ready=0 for 20 cycles -> result and result_valid held stable; single handshake on ready.
//  4 Unstable input: count_in toggles every cycle -> after MAX_TRY=8 tries err=1, result_valid=1.
//     Next start clears err.
//  5 Continuous: cont=1, gate_len=0 -> meas_en pulses exactly 1 cycle; CLEAR re-entered on each handshake.
//     start pulses during busy are ignored.
//  6 FREQ_MEAS_AVG_EN, AVG_LOG2=2: count_in frozen at 100,101,102,103 per pass -> result=101 after 4 passes.

Source files
------------

// File: rtl/freq_meas_pkg.sv
// freq_meas_pkg: shared FSM state type and default timing constants for the frequency-measurement controller
package freq_meas_pkg;
  typedef enum logic [2:0] {IDLE, CLEAR, GATE, HOLD, SAMPLE, DONE} state_t;
  localparam int CLR_CYC_DEF  = 4;
  localparam int HOLD_CYC_DEF = 4;
  localparam int MAX_TRY_DEF  = 8;
endpackage

// File: rtl/freq_meas_sync.sv
// freq_meas_sync: 2-flop synchroniser for the oscillator count plus equal-consecutive-sample detector
// Ports: clk, reset (sync, active-low), en (sampling window; low restarts the fill),
//        d (async count), vld (comparison is meaningful this cycle), stable (two equal synced samples), q (synced value)
module freq_meas_sync #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [N-1:0] d,
  output logic         vld,
  output logic         stable,
  output logic [N-1:0] q
);
  logic [N-1:0] s1_q, s2_q, p_q;
  logic [1:0]   n_q;
  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_q <= '0;
      s2_q <= '0;
      p_q  <= '0;
      n_q  <= '0;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
      p_q  <= s2_q;
      n_q  <= !en ? 2'd0 : (n_q == 2'd3) ? n_q : n_q + 2'd1;
    end
  end
  // After three enabled edges both s2_q and p_q hold samples taken inside the window
  assign vld    = en && (n_q == 2'd3);
  assign stable = vld && (s2_q == p_q);
  assign q      = s2_q;
endmodule

// File: rtl/freq_meas_ctrl.sv
// freq_meas_ctrl: reference-clock controller that clears, gates and samples a ring-oscillator edge counter
// Ports: clk, reset (sync, active-low), start, cont, gate_len, count_in (async) in;
//        meas_clk (clear strobe), meas_en (count window), result, result_valid out; result_ready in; busy, err out
// Option: define FREQ_MEAS_AVG_EN to average 2^AVG_LOG2 passes per result
module freq_meas_ctrl
  import freq_meas_pkg::*;
#(
  parameter int N        = 8,
  parameter int GW       = 16,
  parameter int CLR_CYC  = CLR_CYC_DEF,
  parameter int HOLD_CYC = HOLD_CYC_DEF,
  parameter int MAX_TRY  = MAX_TRY_DEF
`ifdef FREQ_MEAS_AVG_EN
  , parameter int AVG_LOG2 = 2
`endif
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          cont,
  input  logic [GW-1:0] gate_len,
  input  logic [N-1:0]  count_in,
  output logic          meas_clk,
  output logic          meas_en,
  output logic [N-1:0]  result,
  output logic          result_valid,
  input  logic          result_ready,
  output logic          busy,
  output logic          err
);
  localparam int TW = $clog2(MAX_TRY + 1);
  state_t        state_q, state_d;
  logic [GW-1:0] cnt_q, cnt_d, gl_q, gl_d;
  logic [TW-1:0] try_q, try_d;
  logic [N-1:0]  res_q, res_d, smp_val;
  logic          err_q, err_d, mc_q, me_q, rv_q, busy_q;
  logic          smp_vld, smp_stable, fin;
`ifdef FREQ_MEAS_AVG_EN
  localparam int AW = N + AVG_LOG2;
  logic [AW-1:0]       acc_q, acc_d, sum;
  logic [AVG_LOG2-1:0] pass_q, pass_d;
`endif

  freq_meas_sync #(.N(N)) u_sync (
    .clk    (clk),
    .reset  (reset),
    .en     (state_q == SAMPLE),
    .d      (count_in),
    .vld    (smp_vld),
    .stable (smp_stable),
    .q      (smp_val)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    gl_d    = gl_q;
    try_d   = try_q;
    res_d   = res_q;
    err_d   = err_q;
    fin     = 1'b0;
`ifdef FREQ_MEAS_AVG_EN
    acc_d   = acc_q;
    pass_d  = pass_q;
    sum     = acc_q + AW'(smp_val);
`endif
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (start) begin
          state_d = CLEAR;
          gl_d    = (gate_len == '0) ? GW'(1) : gate_len;
          err_d   = 1'b0;
        end
      end
      CLEAR: if (cnt_q == GW'(CLR_CYC - 1)) begin
        state_d = GATE;
        cnt_d   = '0;
      end
      GATE: if (cnt_q == gl_q - 1'b1) begin
        state_d = HOLD;
        cnt_d   = '0;
      end
      HOLD: if (cnt_q == GW'(HOLD_CYC - 1)) begin
        state_d = SAMPLE;
        cnt_d   = '0;
        try_d   = '0;
      end
      SAMPLE: begin
        cnt_d = '0;
        if (smp_vld) begin
          fin   = smp_stable || (try_q == TW'(MAX_TRY - 1));
          err_d = err_q || (fin && !smp_stable);
          try_d = try_q + 1'b1;
        end
      end
      DONE: begin
        cnt_d = '0;
        if (result_ready) state_d = cont ? CLEAR : IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (fin) begin
`ifdef FREQ_MEAS_AVG_EN
      // pass_q wraps to zero after the final pass, ready for the next measurement
      pass_d  = pass_q + 1'b1;
      acc_d   = (&pass_q) ? '0 : sum;
      res_d   = (&pass_q) ? sum[AW-1:AVG_LOG2] : res_q;
      state_d = (&pass_q) ? DONE : CLEAR;
`else
      res_d   = smp_val;
      state_d = DONE;
`endif
    end
  end

  // Outputs are decoded from the next state so they change on the same edge as the state
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      gl_q    <= '0;
      try_q   <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
      mc_q    <= 1'b0;
      me_q    <= 1'b0;
      rv_q    <= 1'b0;
      busy_q  <= 1'b0;
`ifdef FREQ_MEAS_AVG_EN
      acc_q   <= '0;
      pass_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gl_q    <= gl_d;
      try_q   <= try_d;
      res_q   <= res_d;
      err_q   <= err_d;
      mc_q    <= (state_d == CLEAR);
      me_q    <= (state_d == GATE);
      rv_q    <= (state_d == DONE);
      busy_q  <= (state_d != IDLE);
`ifdef FREQ_MEAS_AVG_EN
      acc_q   <= acc_d;
      pass_q  <= pass_d;
`endif
    end
  end

  assign meas_clk     = mc_q;
  assign meas_en      = me_q;
  assign result       = res_q;
  assign result_valid = rv_q;
  assign busy         = busy_q;
  assign err          = err_q;
endmodule
